// File: rtl/frame_pkg.sv
// Shared constants and state encoding for the frame-buffer scanout path.
package frame_pkg;

    localparam int H_PIXELS_DEF = 100;
    localparam int V_LINES_DEF  = 100;
    localparam int PIX_BYTES    = 3;
    localparam int ADDR_W       = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND0,
        ST_SEND1,
        ST_SEND2
    } scan_state_t;

endpackage

// File: rtl/px_line_counter.sv
// Raster pointer: pixel/line counter with line wrap and a frame-end flag.
// The pointer holds at the last pixel of the frame instead of wrapping.
module px_line_counter
    import frame_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] px,
    output logic [ADDR_W-1:0] line,
    output logic              line_end,
    output logic              frame_end
);

    localparam logic [ADDR_W-1:0] PX_LAST = ADDR_W'(H_PIXELS - 1);
    localparam logic [ADDR_W-1:0] LN_LAST = ADDR_W'(V_LINES - 1);

    assign line_end  = (px == PX_LAST);
    assign frame_end = line_end && (line == LN_LAST);

    // Pointer register: clear to (0,0), otherwise step in raster order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px   <= '0;
            line <= '0;
        end else if (clr) begin
            px   <= '0;
            line <= '0;
        end else if (inc && !frame_end) begin
            if (line_end) begin
                px   <= '0;
                line <= line + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Frame store reader: fetches pixels in raster order and serialises each
// into three bytes (low byte first) on a valid/ready stream.
module frame_scanout
    import frame_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int PIX_W    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_line,
    output logic [ADDR_W-1:0] rd_px,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [ADDR_W-1:0] px_out,
    output logic [ADDR_W-1:0] line_out,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done
);

    scan_state_t               state;
    scan_state_t               state_next;
    logic [PIX_BYTES*8-1:0]    pix;
    logic [ADDR_W-1:0]         px;
    logic [ADDR_W-1:0]         line;
    logic                      line_end;
    logic                      frame_end;
    logic                      cnt_clr;
    logic                      cnt_inc;
    logic                      done_next;

    px_line_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES)
    ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .px        (px),
        .line      (line),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // State, pixel holding register and the registered done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pix   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
            if (state == ST_WAIT) begin
                pix <= rd_data[PIX_BYTES*8-1:0];
            end
        end
    end

    // Next-state logic; abort overrides any byte transfer in the same cycle.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    cnt_clr    = 1'b1;
                end
            end
            ST_FETCH: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_SEND0;
            ST_SEND0: if (byte_ready) state_next = ST_SEND1;
            ST_SEND1: if (byte_ready) state_next = ST_SEND2;
            ST_SEND2: begin
                if (byte_ready) begin
                    cnt_inc = 1'b1;
                    if (frame_end) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            cnt_inc    = 1'b0;
            done_next  = 1'b0;
        end
    end

    // Output decode from the current state; everything reads zero in IDLE.
    always_comb begin
        rd_en      = 1'b0;
        rd_line    = '0;
        rd_px      = '0;
        byte_valid = 1'b0;
        byte_out   = '0;
        px_out     = '0;
        line_out   = '0;
        sof        = 1'b0;
        eol        = 1'b0;
        busy       = (state != ST_IDLE);
        unique case (state)
            ST_FETCH: begin
                rd_en   = 1'b1;
                rd_line = line;
                rd_px   = px;
            end
            ST_SEND0, ST_SEND1, ST_SEND2: begin
                byte_valid = 1'b1;
                px_out     = px;
                line_out   = line;
                if (state == ST_SEND0) begin
                    byte_out = pix[7:0];
                    sof      = (px == '0) && (line == '0);
                end else if (state == ST_SEND1) begin
                    byte_out = pix[15:8];
                end else begin
                    byte_out = pix[23:16];
                    eol      = line_end;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: cycle table for the first pixels and control
// corners, randomized frames against a raster-order stream model.
module tb_frame_scanout;

    localparam int H = 3;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        byte_ready;
    logic        rd_en;
    logic [9:0]  rd_line;
    logic [9:0]  rd_px;
    logic [23:0] rd_data;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [9:0]  px_out;
    logic [9:0]  line_out;
    logic        sof;
    logic        eol;
    logic        busy;
    logic        done;

    frame_scanout #(
        .H_PIXELS (H),
        .V_LINES  (V),
        .PIX_W    (24)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_line    (rd_line),
        .rd_px      (rd_px),
        .rd_data    (rd_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .px_out     (px_out),
        .line_out   (line_out),
        .sof        (sof),
        .eol        (eol),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame store: 1-cycle read latency, addressed {line[0], px[1:0]}.
    logic [23:0] mem [8];
    initial forever begin
        @(posedge clk);
        if (rd_en) rd_data <= mem[{rd_line[0], rd_px[1:0]}];
    end

    // All DUT outputs packed for table comparison.
    logic [53:0] outs;
    assign outs = {rd_en, rd_line, rd_px, byte_valid, byte_out, sof, eol,
                   px_out, line_out, busy, done};

    typedef struct packed {
        logic [7:0] b;
        logic [9:0] px;
        logic [9:0] ln;
        logic       sof;
        logic       eol;
    } beat_t;

    beat_t       exp_q[$];
    logic [19:0] fetch_q[$];
    logic        scb_on = 1'b0;
    int          done_cnt = 0;
    logic        hold_prev;
    logic [29:0] snap;

    // Monitor: stream scoreboard, fetch order, hold-under-backpressure, done count.
    initial begin
        hold_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev)
                    chk("hold", {byte_valid, byte_out, px_out, line_out, sof, eol}, {1'b1, snap});
                hold_prev = byte_valid && !byte_ready && !abort;
                snap = {byte_out, px_out, line_out, sof, eol};
                if (scb_on && rd_en) begin
                    if (fetch_q.size() == 0) chk("fetch_extra", 1, 0);
                    else chk("fetch_addr", {rd_line, rd_px}, fetch_q.pop_front());
                end
                if (scb_on && byte_valid && byte_ready && !abort) begin
                    if (exp_q.size() == 0) chk("beat_extra", 1, 0);
                    else chk("beat", {byte_out, px_out, line_out, sof, eol}, exp_q.pop_front());
                end
                if (done) done_cnt++;
            end
        end
    end

    typedef struct {
        logic s, a, y;
        logic en; int ln, px;
        logic vld; logic [7:0] b; logic so, eo;
        int pxo, lno; logic bz, dn;
    } row_t;

    function automatic row_t mk(input logic s, a, y, en, input int ln, px,
                                input logic vld, input logic [7:0] b, input logic so, eo,
                                input int pxo, lno, input logic bz, dn);
        row_t r;
        r.s = s; r.a = a; r.y = y; r.en = en; r.ln = ln; r.px = px;
        r.vld = vld; r.b = b; r.so = so; r.eo = eo; r.pxo = pxo; r.lno = lno;
        r.bz = bz; r.dn = dn;
        return r;
    endfunction

    function automatic logic [53:0] exp_of(input row_t r);
        return {r.en, 10'(r.ln), 10'(r.px), r.vld, r.b, r.so, r.eo,
                10'(r.pxo), 10'(r.lno), r.bz, r.dn};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One whole frame of random pixels with random (or constant) ready.
    task automatic run_frame(input int ready_pct);
        int cycles;
        int d0;
        for (int l = 0; l < V; l++)
            for (int p = 0; p < H; p++)
                mem[{l[0], p[1:0]}] = 24'($urandom);
        for (int l = 0; l < V; l++)
            for (int p = 0; p < H; p++) begin
                logic [23:0] w;
                w = mem[{l[0], p[1:0]}];
                fetch_q.push_back({10'(l), 10'(p)});
                for (int k = 0; k < 3; k++)
                    exp_q.push_back('{b: w[8*k +: 8], px: 10'(p), ln: 10'(l),
                                      sof: (l == 0 && p == 0 && k == 0),
                                      eol: (p == H - 1 && k == 2)});
            end
        scb_on = 1'b1;
        d0 = done_cnt;
        tick;
        start = 1'b1;
        byte_ready = 1'b1;
        tick;
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 2000) begin
            byte_ready = ($urandom_range(0, 99) < ready_pct);
            tick;
            cycles++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        if (ready_pct >= 100) chk("frame_cycles", cycles, 5 * H * V);
        tick;
        chk("done_width", done, 0);
        chk("done_count", done_cnt - d0, 1);
        chk("beats_left", exp_q.size(), 0);
        chk("fetches_left", fetch_q.size(), 0);
        scb_on = 1'b0;
        exp_q.delete();
        fetch_q.delete();
    endtask

    row_t tbl[13];

    initial begin
        int d0;
        int seen_rd;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        byte_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) tick;
        chk("reset_outs", outs, 0);
        reset = 1'b1;
        tick;
        chk("idle_outs", outs, 0);

        // Cycle table: stall in SEND1, start ignored while busy, abort in WAIT,
        // start+abort in IDLE (start wins), abort in FETCH.
        mem[0] = 24'hA1B2C3;
        mem[1] = 24'h445566;
        tbl[0]  = mk(1,0,1, 0,0,0, 0,8'h00,0,0, 0,0, 0,0);
        tbl[1]  = mk(0,0,1, 1,0,0, 0,8'h00,0,0, 0,0, 1,0);
        tbl[2]  = mk(0,0,1, 0,0,0, 0,8'h00,0,0, 0,0, 1,0);
        tbl[3]  = mk(0,0,1, 0,0,0, 1,8'hC3,1,0, 0,0, 1,0);
        tbl[4]  = mk(0,0,0, 0,0,0, 1,8'hB2,0,0, 0,0, 1,0);
        tbl[5]  = mk(1,0,0, 0,0,0, 1,8'hB2,0,0, 0,0, 1,0);
        tbl[6]  = mk(0,0,1, 0,0,0, 1,8'hB2,0,0, 0,0, 1,0);
        tbl[7]  = mk(0,0,1, 0,0,0, 1,8'hA1,0,0, 0,0, 1,0);
        tbl[8]  = mk(0,0,1, 1,0,1, 0,8'h00,0,0, 0,0, 1,0);
        tbl[9]  = mk(0,1,1, 0,0,0, 0,8'h00,0,0, 0,0, 1,0);
        tbl[10] = mk(1,1,0, 0,0,0, 0,8'h00,0,0, 0,0, 0,0);
        tbl[11] = mk(0,1,0, 1,0,0, 0,8'h00,0,0, 0,0, 1,0);
        tbl[12] = mk(0,0,0, 0,0,0, 0,8'h00,0,0, 0,0, 0,0);
        d0 = done_cnt;
        for (int i = 0; i < 13; i++) begin
            start = tbl[i].s;
            abort = tbl[i].a;
            byte_ready = tbl[i].y;
            #1;
            chk($sformatf("row%0d", i), outs, exp_of(tbl[i]));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("table_no_done", done_cnt - d0, 0);

        // Full frames: ready tied high (5 cycles/pixel), then random backpressure.
        run_frame(100);
        run_frame(60);
        run_frame(40);

        // Abort in SEND1 of line 1 pixel 0 together with ready.
        mem[4] = 24'h5A6B7C;
        d0 = done_cnt;
        byte_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (18) tick;
        chk("abort_pre_valid", byte_valid, 1);
        chk("abort_pre_byte", byte_out, 8'h6B);
        chk("abort_pre_pos", {line_out, px_out}, {10'd1, 10'd0});
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_valid", byte_valid, 0);
        chk("abort_busy", busy, 0);
        seen_rd = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd_en) seen_rd++;
            tick;
        end
        chk("abort_no_fetch", seen_rd, 0);
        chk("abort_no_done", done_cnt - d0, 0);

        // Asynchronous reset in WAIT, then a clean rescan from (0,0).
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("wait_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", outs, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick;
        chk("after_reset_outs", outs, 0);
        chk("reset_no_done", done_cnt - d0, 0);
        run_frame(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
